// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: active-low column drive, per-scan priority capture,
// full-scan debounce and key strobe. Define KEYPAD_REPEAT_EN to enable auto-repeat.
module keypad_scanner #(
  parameter int unsigned SCAN_TICKS     = 100000,
  parameter int unsigned DEBOUNCE_SCANS = 4,
  parameter int unsigned REPEAT_DELAY   = 500,
  parameter int unsigned REPEAT_RATE    = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int unsigned TICK_W = (SCAN_TICKS > 2) ? $clog2(SCAN_TICKS) : 1;
  localparam int unsigned CNT_W  = $clog2(DEBOUNCE_SCANS + 1);

  typedef enum logic {IDLE, PRESSED} state_e;

  state_e            state_q, state_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [1:0]        c_q, c_d;
  logic [3:0]        col_q, col_d;
  logic [4:0]        acc_q, acc_d;
  logic [4:0]        last_q, last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        code_q, code_d;
  logic              valid_q, valid_d;
  logic              held_q, held_d;

  logic [4:0]        col_hit;
  logic [4:0]        result;
  logic              sample;
  logic              scan_end;
  logic              stable;

`ifdef KEYPAD_REPEAT_EN
  localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned REP_W   = $clog2(REP_MAX + 1);
  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d, rep_next;
  logic             rep_first_q, rep_first_d;
`else
  logic unused_repeat;
  assign unused_repeat = ^{REPEAT_DELAY, REPEAT_RATE};
`endif

  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'h0: key_map = 4'h1;  4'h1: key_map = 4'h2;  4'h2: key_map = 4'h3;  4'h3: key_map = 4'hA;
      4'h4: key_map = 4'h4;  4'h5: key_map = 4'h5;  4'h6: key_map = 4'h6;  4'h7: key_map = 4'hB;
      4'h8: key_map = 4'h7;  4'h9: key_map = 4'h8;  4'hA: key_map = 4'h9;  4'hB: key_map = 4'hC;
      4'hC: key_map = 4'h0;  4'hD: key_map = 4'hF;  4'hE: key_map = 4'hE;  default: key_map = 4'hD;
    endcase
  endfunction

  // Lowest pressed row in the currently driven column (loop runs high to low so row 0 wins).
  always_comb begin
    col_hit = '0;
    for (int r = 3; r >= 0; r--) begin
      if (!row[r]) col_hit = {1'b1, key_map(2'(r), c_q)};
    end
  end

  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    c_d      = c_q;
    col_d    = col_q;
    acc_d    = acc_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    code_d   = code_q;
    valid_d  = 1'b0;
    held_d   = held_q;
    stable   = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    rep_cnt_d   = rep_cnt_q;
    rep_first_d = rep_first_q;
    rep_next    = rep_cnt_q + REP_W'(1);
`endif

    sample   = (tick_q == TICK_W'(SCAN_TICKS - 1));
    scan_end = sample && (c_q == 2'd3);
    result   = acc_q[4] ? acc_q : col_hit;

    // Column slot timing: sample on the last tick, then move to the next column.
    if (sample) begin
      tick_d = '0;
      c_d    = c_q + 2'd1;
      col_d  = ~(4'b0001 << c_d);
      acc_d  = scan_end ? 5'b0 : result;
    end else begin
      tick_d = tick_q + TICK_W'(1);
    end

    // Debounce across full scans; stable fires only when the count first reaches the target.
    if (scan_end) begin
      if (result == last_q) begin
        if (cnt_q != CNT_W'(DEBOUNCE_SCANS)) begin
          cnt_d  = cnt_q + CNT_W'(1);
          stable = (cnt_d == CNT_W'(DEBOUNCE_SCANS));
        end
      end else begin
        last_d = result;
        cnt_d  = CNT_W'(1);
        stable = (DEBOUNCE_SCANS == 1);
      end
    end

    case (state_q)
      IDLE: begin
        if (stable && result[4]) begin
          state_d = PRESSED;
          code_d  = result[3:0];
          held_d  = 1'b1;
          valid_d = 1'b1;
`ifdef KEYPAD_REPEAT_EN
          rep_cnt_d   = '0;
          rep_first_d = 1'b0;
`endif
        end
      end
      PRESSED: begin
        if (stable && !result[4]) begin
          state_d = IDLE;
          held_d  = 1'b0;
`ifdef KEYPAD_REPEAT_EN
          rep_cnt_d   = '0;
          rep_first_d = 1'b0;
`endif
        end else if (stable && (result[3:0] != code_q)) begin
          code_d  = result[3:0];
          valid_d = 1'b1;
`ifdef KEYPAD_REPEAT_EN
          rep_cnt_d   = '0;
          rep_first_d = 1'b0;
`endif
        end
`ifdef KEYPAD_REPEAT_EN
        // Same key still held: first repeat after REPEAT_DELAY scans, then every REPEAT_RATE.
        else if (scan_end) begin
          if ((!rep_first_q && rep_next == REP_W'(REPEAT_DELAY)) ||
              ( rep_first_q && rep_next == REP_W'(REPEAT_RATE))) begin
            valid_d     = 1'b1;
            rep_cnt_d   = '0;
            rep_first_d = 1'b1;
          end else begin
            rep_cnt_d = rep_next;
          end
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      tick_q  <= '0;
      c_q     <= 2'd0;
      col_q   <= 4'b1110;
      acc_q   <= 5'b0;
      last_q  <= 5'b0;
      cnt_q   <= '0;
      code_q  <= 4'h0;
      valid_q <= 1'b0;
      held_q  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt_q   <= '0;
      rep_first_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      c_q     <= c_d;
      col_q   <= col_d;
      acc_q   <= acc_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      held_q  <= held_d;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt_q   <= rep_cnt_d;
      rep_first_q <= rep_first_d;
`endif
    end
  end

  assign col       = col_q;
  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign key_held  = held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a modelled 4x4 switch matrix
// (SCAN_TICKS=4, DEBOUNCE_SCANS=3, so one full scan is 16 clocks).
module tb_keypad_scanner;

`ifdef KEYPAD_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;

  logic [15:0] keys;
  int          checks;
  int          errors;
  int          cyc;
  int          pulses;
  int          last_pulse_cyc;
  logic [3:0]  pulse_code;

  keypad_scanner #(
    .SCAN_TICKS(4), .DEBOUNCE_SCANS(3), .REPEAT_DELAY(2), .REPEAT_RATE(1)
  ) dut (
    .clk(clk), .reset(reset), .row(row), .col(col),
    .key_code(key_code), .key_valid(key_valid), .key_held(key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Switch matrix: row r pulled low when its column is driven and key (r,c) is closed.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  function automatic logic [15:0] kb(input int r, input int c);
    kb = 16'(1) << (r*4 + c);
  endfunction

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (key_valid === 1'b1) begin
        pulses++;
        last_pulse_cyc = cyc;
        pulse_code = key_code;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    cyc = 0;
    pulses = 0;
    last_pulse_cyc = -1;
    pulse_code = 4'h0;
  endtask

  task automatic test_reset();
    keys = 16'h0;
    do_reset();
    checks++; if (col !== 4'b1110) begin errors++; $display("FAIL reset_col: got %b expected 1110", col); end
    checks++; if (key_code !== 4'h0) begin errors++; $display("FAIL reset_code: got %h expected 0", key_code); end
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", key_valid); end
    checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL reset_held: got %b expected 0", key_held); end
  endtask

  task automatic test_idle_scan();
    logic [3:0] exp_col;
    keys = 16'h0;
    do_reset();
    for (int k = 0; k < 32; k++) begin
      step(1);
      exp_col = ~(4'b0001 << ((cyc / 4) % 4));
      checks++;
      if (col !== exp_col) begin
        errors++; $display("FAIL idle_col cyc %0d: got %b expected %b", cyc, col, exp_col);
      end
    end
    step(64);
    checks++; if (pulses !== 0) begin errors++; $display("FAIL idle_pulses: got %0d expected 0", pulses); end
    checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL idle_held: got %b expected 0", key_held); end
  endtask

  task automatic test_single_key();
    keys = kb(1, 1);
    do_reset();
    step(47);
    checks++; if (pulses !== 0) begin errors++; $display("FAIL single_early: got %0d pulses expected 0", pulses); end
    step(1);
    checks++; if (last_pulse_cyc !== 48) begin errors++; $display("FAIL single_time: got %0d expected 48", last_pulse_cyc); end
    checks++; if (key_code !== 4'h5) begin errors++; $display("FAIL single_code: got %h expected 5", key_code); end
    checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL single_held: got %b expected 1", key_held); end
    step(1);
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL single_width: got %b expected 0", key_valid); end
    step(63);
    checks++;
    if (pulses !== (REP ? 4 : 1)) begin
      errors++; $display("FAIL single_hold_pulses: got %0d expected %0d", pulses, REP ? 4 : 1);
    end
    checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL single_hold_held: got %b expected 1", key_held); end
  endtask

  task automatic test_priority();
    keys = kb(0, 0) | kb(3, 3);
    do_reset();
    step(48);
    checks++; if (last_pulse_cyc !== 48) begin errors++; $display("FAIL prio_time: got %0d expected 48", last_pulse_cyc); end
    checks++; if (key_code !== 4'h1) begin errors++; $display("FAIL prio_code: got %h expected 1", key_code); end
  endtask

  task automatic test_chatter();
    keys = kb(2, 1);
    do_reset();
    for (int s = 0; s < 10; s++) begin
      step(16);
      keys = keys ^ kb(2, 1);
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL chatter_pulses: got %0d expected 0", pulses); end
    checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL chatter_held: got %b expected 0", key_held); end
    checks++; if (key_code !== 4'h0) begin errors++; $display("FAIL chatter_code: got %h expected 0", key_code); end
  endtask

  task automatic test_back_to_back();
    int p0;
    keys = kb(1, 1);
    do_reset();
    step(80);
    keys = kb(2, 2);
    step(47);
    checks++; if (key_code !== 4'h5) begin errors++; $display("FAIL switch_early_code: got %h expected 5", key_code); end
    step(1);
    checks++; if (last_pulse_cyc !== 128) begin errors++; $display("FAIL switch_time: got %0d expected 128", last_pulse_cyc); end
    checks++; if (pulse_code !== 4'h9) begin errors++; $display("FAIL switch_code: got %h expected 9", pulse_code); end
    checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL switch_held: got %b expected 1", key_held); end
    p0 = pulses;
    keys = 16'h0;
    step(47);
    checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL release_early: got %b expected 1", key_held); end
    step(1);
    checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL release_held: got %b expected 0", key_held); end
    checks++; if (key_code !== 4'h9) begin errors++; $display("FAIL release_code: got %h expected 9", key_code); end
    checks++;
    if ((pulses - p0) !== (REP ? 1 : 0)) begin
      errors++; $display("FAIL release_pulses: got %0d expected %0d", pulses - p0, REP ? 1 : 0);
    end
  endtask

  task automatic test_reset_mid();
    keys = kb(0, 1);
    do_reset();
    step(32);
    do_reset();
    checks++; if (col !== 4'b1110) begin errors++; $display("FAIL midrst_col: got %b expected 1110", col); end
    checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL midrst_held: got %b expected 0", key_held); end
    checks++; if (key_code !== 4'h0) begin errors++; $display("FAIL midrst_code: got %h expected 0", key_code); end
    step(47);
    checks++; if (pulses !== 0) begin errors++; $display("FAIL midrst_early: got %0d pulses expected 0", pulses); end
    step(1);
    checks++; if (last_pulse_cyc !== 48) begin errors++; $display("FAIL midrst_time: got %0d expected 48", last_pulse_cyc); end
    checks++; if (key_code !== 4'h2) begin errors++; $display("FAIL midrst_key: got %h expected 2", key_code); end
  endtask

`ifdef KEYPAD_REPEAT_EN
  task automatic test_repeat();
    keys = kb(0, 3);
    do_reset();
    step(48);
    checks++; if (last_pulse_cyc !== 48) begin errors++; $display("FAIL rep_accept: got %0d expected 48", last_pulse_cyc); end
    step(16);
    checks++; if (pulses !== 1) begin errors++; $display("FAIL rep_gap: got %0d expected 1", pulses); end
    step(16);
    checks++; if (last_pulse_cyc !== 80) begin errors++; $display("FAIL rep_first: got %0d expected 80", last_pulse_cyc); end
    step(16);
    checks++; if (last_pulse_cyc !== 96) begin errors++; $display("FAIL rep_second: got %0d expected 96", last_pulse_cyc); end
    step(16);
    checks++; if (pulses !== 4) begin errors++; $display("FAIL rep_count: got %0d expected 4", pulses); end
    checks++; if (pulse_code !== 4'hA) begin errors++; $display("FAIL rep_code: got %h expected A", pulse_code); end
  endtask
`endif

  initial begin
    reset = 1'b1;
    keys = 16'h0;
    checks = 0;
    errors = 0;
    cyc = 0;
    pulses = 0;
    last_pulse_cyc = -1;
    pulse_code = 4'h0;
    test_reset();
    test_idle_scan();
    test_single_key();
    test_priority();
    test_chatter();
    test_back_to_back();
    test_reset_mid();
`ifdef KEYPAD_REPEAT_EN
    test_repeat();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
